muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide sequencer that adds the RV32M instructions to the execute stage alongside the existing single-cycle ALU. It accepts one operation from EX, holds the pipeline with a stall while it iterates over a shared 33-bit add/subtract datapath, and returns a registered result with a one-cycle done pulse. Divide-by-zero and signed overflow are resolved without iterating.

## Interface
- XLEN, 32, operand and result width; the internal counter width is $clog2(XLEN).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  EX holds an M-extension instruction; held high with stable operands while stall_o=1.
- funct3_i  in  3  MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- rs1_i  in  XLEN  operand A (dividend / multiplicand).
- rs2_i  in  XLEN  operand B (divisor / multiplier).
- flush_i  in  1  EX instruction squashed; aborts any operation.
- stall_o  out  1  freeze IF/ID/EX; equals valid_i && state!=DONE && !flush_i.
- done_o  out  1  high exactly in state DONE; result_o is valid.
- result_o  out  XLEN  registered result; holds its value until the next DONE.

## Operation
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, valid_i=1, no flush: latch the operands and funct3.
  - Record operand signs: signed for MULH/DIV/REM (both operands), for MULHSU (rs1 only).
  - Load the absolute values.
  - Set count=XLEN-1.
  - Go to CALC.
- IDLE special cases go straight to DONE and skip CALC and FIXUP:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow, rs1=0x80000000 and rs2=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC does one iteration per cycle.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring shift-subtract using a 33-bit remainder.
  - count decrements each cycle; at count=0 go to FIXUP.
- FIXUP applies the sign correction.
  - Product: negated if the signs differ.
  - Quotient: negated if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Selects the result: MUL gives the low word; MULH/MULHSU/MULHU give the high word; DIV/DIVU the quotient; REM/REMU the remainder.
  - Registers result_o, then goes to DONE.
- DONE: done_o=1 and stall_o=0, so the pipeline advances this cycle. Go unconditionally to IDLE.
- Each accepted operation produces exactly one done pulse. There is no back-to-back accept in DONE.
- flush_i=1 in any state: next state is IDLE, no done pulse, result_o unchanged. flush has priority over every transition.
- valid_i dropping in CALC/FIXUP without flush is a protocol violation; the operation still completes.

## Timing
- Accept edge is T0.
  - Normal path: CALC cycles T1..T32, FIXUP at T33, done_o=1 at T34.
  - Special cases: done_o=1 at T1.
- stall_o is combinational from valid_i, state and flush_i, and is low in the DONE cycle.
- Reset values: state=IDLE, count=0, result_o=0, done_o=0.
  - stall_o=0 until valid_i rises.
- Reset asserted mid-operation: immediate return to IDLE. The operation is lost with no done.

## Structure
- Package muldiv_pkg holds:
  - the funct3 encoding enum (MUL..REMU);
  - the state enum (IDLE, CALC, FIXUP, DONE);
  - the constants INT_MIN and ALL_ONES, parameterised on XLEN.
- Single module. The shared 33-bit adder/subtractor is inlined; no sub-module is warranted.
- The decoder that sends M-instructions here versus to the ALU is in the controller, not in this block.

## Test plan
- MUL, rs1=7, rs2=0xFFFFFFFD (-3) -> done at T34, result_o=0xFFFFFFEB; stall_o high from T0 through T33.
- MULH, rs1=rs2=0x80000000 -> 0x40000000; MULHU with the same operands -> 0x40000000; MULHSU, rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14 and REMU -> 2; DIV -100/7 -> 0xFFFFFFF2 (-14) and REM -> 0xFFFFFFFE (-2).
- DIV 5/0 -> 0xFFFFFFFF with done at T1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with done at T1; REM of the same -> 0.
- flush_i pulsed at T10 of a DIV -> IDLE at T11, no done_o, result_o keeps its previous value; a new MUL accepted at T11 completes at T45.
- rst_n low at T20 of a MUL -> state IDLE with result_o=0, no done; two back-to-back operations each give exactly one done pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    // funct3 encoding of the M-extension ops
    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_e;

    // Two's-complement magnitude when the operand is treated as negative
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared
// 33-bit add/subtract datapath, stalling EX until the result is ready.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    state_e              state, state_nxt;
    funct3_e             op;
    logic                sign_a, sign_b;
    logic [XLEN-1:0]     addend;   // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0]   prod;     // product; low half is dividend/quotient for div
    logic [XLEN-1:0]     rem;
    logic [CNT_W-1:0]    count;

    // Operand decode on the incoming instruction
    logic            sa_in, sb_in, div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    assign sa_in    = (funct3_i == MULH || funct3_i == MULHSU ||
                       funct3_i == DIV  || funct3_i == REM) && rs1_i[XLEN-1];
    assign sb_in    = (funct3_i == MULH || funct3_i == DIV || funct3_i == REM) && rs2_i[XLEN-1];
    assign abs_a    = abs_val(rs1_i, sa_in);
    assign abs_b    = abs_val(rs2_i, sb_in);
    assign div_zero = funct3_i[2] && (rs2_i == '0);
    assign div_ovf  = (funct3_i == DIV || funct3_i == REM) &&
                      (rs1_i == INT_MIN) && (rs2_i == ALL_ONES);
    assign special  = div_zero || div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU
    assign special_res = div_zero ? (funct3_i[1] ? rs1_i : ALL_ONES)
                                  : (funct3_i[1] ? '0    : INT_MIN);

    // Shared adder: add for multiply, subtract with carry-out compare for divide
    logic            is_div, no_borrow;
    logic [XLEN:0]   shifted, add_x, add_y;
    logic [XLEN+1:0] add_res;

    assign is_div    = op[2];
    assign shifted   = {rem, prod[XLEN-1]};
    assign add_x     = is_div ? shifted : {1'b0, prod[2*XLEN-1:XLEN]};
    assign add_y     = {1'b0, addend};
    assign add_res   = {1'b0, add_x} + {1'b0, (is_div ? ~add_y : add_y)}
                     + {{(XLEN+1){1'b0}}, is_div};
    assign no_borrow = add_res[XLEN+1];

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign prod_s = (sign_a ^ sign_b) ? (~prod + 1'b1) : prod;
    assign quo_s  = (sign_a ^ sign_b) ? (~prod[XLEN-1:0] + 1'b1) : prod[XLEN-1:0];
    assign rem_s  = sign_a ? (~rem + 1'b1) : rem;

    // Pick the architectural result for the latched op
    always_comb begin
        fix_res = rem_s;
        case (op)
            MUL:                 fix_res = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_res = quo_s;
            default:             fix_res = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_i) state_nxt = special ? DONE : CALC;
            CALC:    if (count == '0) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    // Datapath: operand latch, iteration, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op       <= MUL;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            addend   <= '0;
            prod     <= '0;
            rem      <= '0;
            count    <= '0;
            result_o <= '0;
        end else if (!flush_i) begin
            case (state)
                IDLE: if (valid_i) begin
                    op     <= funct3_e'(funct3_i);
                    sign_a <= sa_in;
                    sign_b <= sb_in;
                    count  <= CNT_W'(XLEN-1);
                    rem    <= '0;
                    if (funct3_i[2]) begin
                        addend <= abs_b;
                        prod   <= {{XLEN{1'b0}}, abs_a};
                    end else begin
                        addend <= abs_a;
                        prod   <= {{XLEN{1'b0}}, abs_b};
                    end
                    if (special) result_o <= special_res;
                end
                CALC: begin
                    count <= count - 1'b1;
                    if (is_div) begin
                        rem              <= no_borrow ? add_res[XLEN-1:0] : shifted[XLEN-1:0];
                        prod[XLEN-1:0]   <= {prod[XLEN-2:0], no_borrow};
                    end else if (prod[0]) begin
                        prod <= {add_res[XLEN:0], prod[XLEN-1:1]};
                    end else begin
                        prod <= {1'b0, prod[2*XLEN-1:1]};
                    end
                end
                FIXUP:   result_o <= fix_res;
                default: ;
            endcase
        end
    end

    assign stall_o = valid_i && (state != DONE) && !flush_i;
    assign done_o  = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result/latency scoreboard.
module tb_muldiv_unit;

    logic        clk, rst_n, valid_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        stall_o, done_o;
    logic [31:0] result_o;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_res = '0;

    muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive an op in the current cycle (caller sits at a negedge) and queue its expectation
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input string tag,
                         input bit chk_stall);
        exp_t e;
        valid_i  = 1'b1;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        e.res = res; e.lat = lat; e.tag = tag;
        sb.push_back(e);
        #1;
        if (chk_stall) check({tag, "_stall_t0"}, stall_o, 1);
    endtask

    // Run until done_o, checking stall each busy cycle; ends at the DONE-cycle negedge
    task automatic wait_done();
        int   lat;
        exp_t e;
        lat = 0;
        do begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (done_o !== 1'b1) check("stall_busy", stall_o, 1);
        end while (done_o !== 1'b1 && lat < 200);
        check("stall_done", stall_o, 0);
        check("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_lat"}, lat, e.lat);
            check({e.tag, "_res"}, result_o, e.res);
            last_res = e.res;
        end
    endtask

    // Drop valid after DONE and confirm the pulse lasted one cycle
    task automatic finish_op();
        valid_i = 1'b0;
        @(negedge clk);
        check("done_single", done_o, 0);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'b000; rs1_i = '0; rs2_i = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result_o, 32'h0);
        check("rst_done", done_o, 0);
        check("rst_stall", stall_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_stall", stall_o, 0);

        // Multiply family
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul", 1'b1);
        wait_done(); finish_op();
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh", 1'b1);
        wait_done(); finish_op();
        issue(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulhu", 1'b1);
        wait_done(); finish_op();
        issue(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, "mulhsu", 1'b1);
        wait_done(); finish_op();

        // Divide family
        issue(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu", 1'b1);
        wait_done(); finish_op();
        issue(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu", 1'b1);
        wait_done(); finish_op();
        issue(3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, "rem", 1'b1);
        wait_done(); finish_op();
        issue(3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, "div", 1'b1);
        wait_done(); finish_op();

        // Flush mid-divide, then a MUL accepted right after
        issue(3'b100, 32'd1000, 32'd3, 32'd333, 34, "div_flushed", 1'b1);
        void'(sb.pop_back());
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            check("flush_nodone", done_o, 0);
        end
        flush_i = 1'b1;
        #1 check("flush_stall", stall_o, 0);
        @(posedge clk); @(negedge clk);
        flush_i = 1'b0;
        check("flush_done", done_o, 0);
        check("flush_keep", result_o, last_res);
        issue(3'b000, 32'd6, 32'd7, 32'd42, 34, "mul_after_flush", 1'b1);
        wait_done(); finish_op();

        // Special cases resolve in one cycle
        issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div0", 1'b1);
        wait_done(); finish_op();
        issue(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem0", 1'b1);
        wait_done(); finish_op();
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 1'b1);
        wait_done(); finish_op();
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf", 1'b1);
        wait_done(); finish_op();

        // Reset mid-multiply
        issue(3'b000, 32'h0001_2345, 32'h10, 32'h0012_3450, 34, "mul_reset", 1'b1);
        void'(sb.pop_back());
        repeat (20) begin
            @(posedge clk); @(negedge clk);
        end
        rst_n = 1'b0; valid_i = 1'b0;
        #1;
        check("mreset_result", result_o, 32'h0);
        check("mreset_done", done_o, 0);
        check("mreset_stall", stall_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o === 1'b1) pulses++;
        end
        check("mreset_nopulse", pulses, 0);

        // Back-to-back: second op driven during the first op's DONE cycle
        issue(3'b000, 32'h0001_2345, 32'h10, 32'h0012_3450, 34, "b2b_1", 1'b1);
        wait_done();
        issue(3'b101, 32'd100, 32'd7, 32'd14, 35, "b2b_2", 1'b0);
        wait_done(); finish_op();

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if something wedges the sequence
    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

endmodule
